// File: rtl/seg7_scan_driver.sv
`timescale 1ns / 1ps
// Time-multiplexed common-anode 7-segment hex display driver.
// The displayed value is snapshotted once per scan frame so a frame never mixes two values.
module seg7_scan_driver #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  blank,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    output logic [6:0]            seg,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);

    localparam int unsigned DivW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned DigW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(REFRESH_DIV - 1);
    localparam logic [DigW-1:0] DigLast = DigW'(DIGITS - 1);

    logic [DivW-1:0]     div_cnt_q, div_cnt_d;
    logic [DigW-1:0]     dig_q, dig_d;
    logic [4*DIGITS-1:0] value_q;
    logic [DIGITS-1:0]   dp_q;
    logic                frame_tick_q;
    logic [6:0]          seg_q, seg_d;
    logic                dp_n_q, dp_n_d;
    logic [DIGITS-1:0]   an_q, an_d;

    logic                div_wrap;
    logic                frame_end;
    logic [DIGITS-1:0]   lead_zero;
    logic                zero_acc;
    logic [3:0]          nib;
    logic                dp_sel;
    logic                digit_blank;

    function automatic logic [6:0] hexdec(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Prescaler and digit counter; both free-run independently of en.
    always_comb begin
        div_wrap  = (div_cnt_q == DivLast);
        frame_end = div_wrap && (dig_q == DigLast);
        div_cnt_d = div_wrap ? '0 : div_cnt_q + DivW'(1);
        dig_d     = dig_q;
        if (frame_end) begin
            dig_d = '0;
        end else if (div_wrap) begin
            dig_d = dig_q + DigW'(1);
        end
    end

    // lead_zero[k]: nibbles k..DIGITS-1 of the snapshot are all zero.
    always_comb begin
        lead_zero = '0;
        zero_acc  = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_acc     = zero_acc & (value_q[4*i +: 4] == 4'h0);
            lead_zero[i] = zero_acc;
        end
    end

    always_comb begin
        nib         = '0;
        dp_sel      = 1'b0;
        digit_blank = 1'b0;
        an_d        = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_q == DigW'(i)) begin
                nib         = value_q[4*i +: 4];
                dp_sel      = dp_q[i];
                digit_blank = blank && (i != 0) && lead_zero[i];
                if (en) begin
                    an_d[i] = 1'b0;
                end
            end
        end
        seg_d  = (en && !digit_blank) ? hexdec(nib) : 7'h7F;
        dp_n_d = en ? ~dp_sel : 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q    <= '0;
            dig_q        <= '0;
            value_q      <= '0;
            dp_q         <= '0;
            frame_tick_q <= 1'b0;
            seg_q        <= 7'h7F;
            dp_n_q       <= 1'b1;
            an_q         <= '1;
        end else begin
            div_cnt_q    <= div_cnt_d;
            dig_q        <= dig_d;
            frame_tick_q <= frame_end;
            if (frame_end) begin
                value_q <= value;
                dp_q    <= dp;
            end
            seg_q  <= seg_d;
            dp_n_q <= dp_n_d;
            an_q   <= an_d;
        end
    end

    assign seg        = seg_q;
    assign dp_n       = dp_n_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
`timescale 1ns / 1ps
// Directed bench for seg7_scan_driver with DIGITS=4, REFRESH_DIV=4 (16-cycle frames).
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        blank = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp = 4'h0;
    logic [6:0]  seg;
    logic        dp_n;
    logic [3:0]  an;
    logic        frame_tick;

    int passed = 0;
    int total  = 0;
    // Rising edges since the last reset release; output after edge c shows digit ((c-1)/4)%4.
    int cyc    = 0;

    seg7_scan_driver #(
        .DIGITS      (4),
        .REFRESH_DIV (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .blank      (blank),
        .value      (value),
        .dp         (dp),
        .seg        (seg),
        .dp_n       (dp_n),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: run still active at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Advance to the next snapshot edge (always at least one edge).
    task automatic wait_frame();
        do tick(); while (cyc % 16 != 0);
    endtask

    task automatic test_reset();
        logic [3:0] exp_an;
        rst = 1'b0;
        en  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (an !== 4'hF) $display("FAIL reset_an: got %h want F", an); else passed++;
        total++; if (seg !== 7'h7F) $display("FAIL reset_seg: got %h want 7F", seg); else passed++;
        total++; if (dp_n !== 1'b1) $display("FAIL reset_dp_n: got %b want 1", dp_n); else passed++;
        total++;
        if (frame_tick !== 1'b0) $display("FAIL reset_tick: got %b want 0", frame_tick);
        else passed++;
        rst = 1'b1;
        cyc = 0;
        tick();
        total++; if (an !== 4'hE) $display("FAIL first_an: got %h want E", an); else passed++;
        total++; if (seg !== 7'h40) $display("FAIL first_seg: got %h want 40", seg); else passed++;
        repeat (3) tick();
        total++; if (an !== 4'hE) $display("FAIL dwell_an: got %h want E", an); else passed++;
        tick();
        exp_an = 4'hD;
        total++; if (an !== exp_an) $display("FAIL second_an: got %h want D", an); else passed++;
        // Asynchronous reset: outputs drop without any clock edge.
        #2;
        rst = 1'b0;
        #1;
        total++; if (an !== 4'hF) $display("FAIL async_an: got %h want F", an); else passed++;
        total++; if (seg !== 7'h7F) $display("FAIL async_seg: got %h want 7F", seg); else passed++;
        #1;
        rst = 1'b1;
        cyc = 0;
    endtask

    task automatic test_scan();
        logic [3:0] exp_an [4]  = '{4'hE, 4'hD, 4'hB, 4'h7};
        logic [6:0] exp_seg [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};
        int ticks = 0;
        value = 16'h12AF;
        blank = 1'b0;
        wait_frame();
        total++;
        if (frame_tick !== 1'b1) $display("FAIL scan_tick: got %b want 1", frame_tick);
        else passed++;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (frame_tick === 1'b1) ticks++;
            total++;
            if (an !== exp_an[i/4]) $display("FAIL scan_an[%0d]: got %h want %h", i, an, exp_an[i/4]);
            else passed++;
            total++;
            if (seg !== exp_seg[i/4])
                $display("FAIL scan_seg[%0d]: got %h want %h", i, seg, exp_seg[i/4]);
            else passed++;
        end
        total++; if (ticks != 1) $display("FAIL scan_tick_count: got %0d want 1", ticks); else passed++;
    endtask

    task automatic test_tearing();
        logic [6:0] old_seg [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};
        logic [6:0] new_seg [4] = '{7'h02, 7'h12, 7'h19, 7'h30};
        int ticks = 0;
        int d;
        repeat (5) tick();
        value = 16'h3456;
        while (cyc % 16 != 0) begin
            tick();
            if (frame_tick === 1'b1) ticks++;
            d = ((cyc - 1) % 16) / 4;
            total++;
            if (seg !== old_seg[d]) $display("FAIL tear_seg@%0d: got %h want %h", cyc, seg, old_seg[d]);
            else passed++;
        end
        total++; if (ticks != 1) $display("FAIL tear_tick_count: got %0d want 1", ticks); else passed++;
        for (int i = 0; i < 16; i++) begin
            tick();
            total++;
            if (seg !== new_seg[i/4])
                $display("FAIL tear_new_seg[%0d]: got %h want %h", i, seg, new_seg[i/4]);
            else passed++;
        end
    endtask

    task automatic test_blanking();
        logic [15:0] vals [3]   = '{16'h0005, 16'h0000, 16'h0005};
        logic        blanks [3] = '{1'b1, 1'b1, 1'b0};
        logic [6:0]  exp_seg [3][4] = '{'{7'h12, 7'h7F, 7'h7F, 7'h7F},
                                         '{7'h40, 7'h7F, 7'h7F, 7'h7F},
                                         '{7'h12, 7'h40, 7'h40, 7'h40}};
        logic [3:0]  exp_an [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
        for (int s = 0; s < 3; s++) begin
            value = vals[s];
            blank = blanks[s];
            wait_frame();
            for (int i = 0; i < 16; i++) begin
                tick();
                total++;
                if (seg !== exp_seg[s][i/4])
                    $display("FAIL blank%0d_seg[%0d]: got %h want %h", s, i, seg, exp_seg[s][i/4]);
                else passed++;
                total++;
                if (an !== exp_an[i/4])
                    $display("FAIL blank%0d_an[%0d]: got %h want %h", s, i, an, exp_an[i/4]);
                else passed++;
            end
        end
    endtask

    task automatic test_enable();
        logic exp_tick;
        dp = 4'hF;
        repeat (5) tick();
        en = 1'b0;
        repeat (20) begin
            tick();
            exp_tick = (cyc % 16 == 0);
            total++; if (an !== 4'hF) $display("FAIL dis_an@%0d: got %h want F", cyc, an); else passed++;
            total++;
            if (seg !== 7'h7F) $display("FAIL dis_seg@%0d: got %h want 7F", cyc, seg); else passed++;
            total++;
            if (dp_n !== 1'b1) $display("FAIL dis_dp_n@%0d: got %b want 1", cyc, dp_n); else passed++;
            total++;
            if (frame_tick !== exp_tick)
                $display("FAIL dis_tick@%0d: got %b want %b", cyc, frame_tick, exp_tick);
            else passed++;
        end
        // Internal dig is 2 here; scanning must resume there, not at digit 0.
        en = 1'b1;
        tick();
        total++; if (an !== 4'hB) $display("FAIL resume_an: got %h want B", an); else passed++;
        total++; if (seg !== 7'h40) $display("FAIL resume_seg: got %h want 40", seg); else passed++;
        total++; if (dp_n !== 1'b0) $display("FAIL resume_dp_n: got %b want 0", dp_n); else passed++;
    endtask

    task automatic test_dp();
        logic [3:0] exp_an [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
        logic       exp_dp;
        dp = 4'h0;
        wait_frame();
        dp = 4'b0100;
        for (int i = 0; i < 16; i++) begin
            tick();
            total++;
            if (dp_n !== 1'b1) $display("FAIL dp_old[%0d]: got %b want 1", i, dp_n); else passed++;
        end
        for (int i = 0; i < 16; i++) begin
            tick();
            exp_dp = (i / 4 == 2) ? 1'b0 : 1'b1;
            total++;
            if (an !== exp_an[i/4]) $display("FAIL dp_an[%0d]: got %h want %h", i, an, exp_an[i/4]);
            else passed++;
            total++;
            if (dp_n !== exp_dp) $display("FAIL dp_new[%0d]: got %b want %b", i, dp_n, exp_dp);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_tearing();
        test_blanking();
        test_enable();
        test_dp();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
